// File: rtl/stb_pkg.sv
// Shared types for the store buffer: entry layout for the default 32-bit
// configuration and the drain FSM state encoding.
package stb_pkg;

    localparam int STB_ADDR_WIDTH = 32;
    localparam int STB_DATA_WIDTH = 32;
    localparam int STB_SEL_WIDTH  = STB_DATA_WIDTH / 8;

    typedef struct packed {
        logic                      valid;
        logic [STB_ADDR_WIDTH-1:0] addr;
        logic [STB_DATA_WIDTH-1:0] data;
        logic [STB_SEL_WIDTH-1:0]  sel;
    } stb_entry_t;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } stb_state_e;

endpackage

// File: rtl/stb_fwd_lookup.sv
// Combinational store-to-load lookup: walks entries from oldest to youngest so
// that younger stores overwrite older ones lane by lane.
module stb_fwd_lookup #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int BYTE_SEL_WIDTH = DATA_WIDTH / 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int PTR_W          = $clog2(FIFO_DEPTH)
) (
    input  logic [ADDR_WIDTH-1:0]                      ld_word,
    input  logic [FIFO_DEPTH-1:0]                      entry_valid,
    input  logic [FIFO_DEPTH-1:0][ADDR_WIDTH-1:0]      entry_addr,
    input  logic [FIFO_DEPTH-1:0][DATA_WIDTH-1:0]      entry_data,
    input  logic [FIFO_DEPTH-1:0][BYTE_SEL_WIDTH-1:0]  entry_sel,
    input  logic [PTR_W-1:0]                           head_ptr,
    output logic [BYTE_SEL_WIDTH-1:0]                  covered,
    output logic [DATA_WIDTH-1:0]                      data
);

    logic [FIFO_DEPTH-1:0] match;
    logic [PTR_W-1:0]      idx;

    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_match
            assign match[gi] = entry_valid[gi] && (entry_addr[gi] == ld_word);
        end
    endgenerate

    always_comb begin
        covered = '0;
        data    = '0;
        idx     = '0;
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            idx = head_ptr + PTR_W'(k);
            if (match[idx]) begin
                for (int b = 0; b < BYTE_SEL_WIDTH; b++) begin
                    if (entry_sel[idx][b]) begin
                        covered[b]        = 1'b1;
                        data[b*8 +: 8]    = entry_data[idx][b*8 +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/store_buffer_fwd.sv
// Store buffer between the LSU and the dcache write port, with write
// coalescing into the youngest entry, byte-level load forwarding and fence.
module store_buffer_fwd
    import stb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int BYTE_SEL_WIDTH = DATA_WIDTH / 8,
    parameter int FIFO_DEPTH     = 4,
    parameter bit COALESCE_EN    = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_WIDTH-1:0]     lsudbus2stb_addr,
    input  logic [DATA_WIDTH-1:0]     lsudbus2stb_wdata,
    input  logic [BYTE_SEL_WIDTH-1:0] lsudbus2stb_sel_byte,
    input  logic                      lsudbus2stb_w_en,
    input  logic                      lsudbus2stb_req,
    input  logic                      dmem_sel_i,
    output logic                      stb2dbuslsu_stall,
    output logic                      stb2dbuslsu_ack,
    input  logic [ADDR_WIDTH-1:0]     ld_addr,
    input  logic [BYTE_SEL_WIDTH-1:0] ld_sel_byte,
    input  logic                      ld_valid,
    output logic                      ld_fwd_hit,
    output logic [DATA_WIDTH-1:0]     ld_fwd_data,
    output logic                      ld_conflict,
    input  logic                      fence_i,
    output logic [ADDR_WIDTH-1:0]     stb2dcache_addr,
    output logic [DATA_WIDTH-1:0]     stb2dcache_wdata,
    output logic [BYTE_SEL_WIDTH-1:0] stb2dcache_sel_byte,
    output logic                      stb2dcache_w_en,
    output logic                      stb2dcache_req,
    output logic                      dmem_sel_o,
    input  logic                      dcache2stb_ack,
    output logic                      stb2dcache_empty
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W-1:0]      PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W:0]        CNT_ONE   = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]        CNT_FULL  = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(BYTE_SEL_WIDTH - 1);

    logic [FIFO_DEPTH-1:0]                     valid_reg;
    logic [FIFO_DEPTH-1:0][ADDR_WIDTH-1:0]     addr_reg;
    logic [FIFO_DEPTH-1:0][DATA_WIDTH-1:0]     data_reg;
    logic [FIFO_DEPTH-1:0][BYTE_SEL_WIDTH-1:0] sel_reg;

    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg, youngest_ptr;
    logic [PTR_W:0]   count_reg, count_next;
    stb_state_e       state_reg, state_next;
    logic             ack_reg;

    logic                      full, empty, in_flight;
    logic [ADDR_WIDTH-1:0]     store_word, ld_word;
    logic                      coalesce_possible, accept, do_push, do_merge, do_pop;
    logic [DATA_WIDTH-1:0]     merge_data, fwd_data;
    logic [BYTE_SEL_WIDTH-1:0] covered, req_covered;

    assign full         = (count_reg == CNT_FULL);
    assign empty        = (count_reg == '0);
    assign in_flight    = (state_reg == REQ);
    assign youngest_ptr = wr_ptr_reg - PTR_ONE;
    assign store_word   = lsudbus2stb_addr & WORD_MASK;
    assign ld_word      = ld_addr & WORD_MASK;

    // The youngest entry is only locked when it is also the head being drained.
    assign coalesce_possible = COALESCE_EN && !empty
                            && (addr_reg[youngest_ptr] == store_word)
                            && !(in_flight && (youngest_ptr == rd_ptr_reg));

    assign stb2dbuslsu_stall = fence_i | (full & ~coalesce_possible);
    assign accept   = lsudbus2stb_req & lsudbus2stb_w_en & dmem_sel_i & ~stb2dbuslsu_stall;
    assign do_merge = accept & coalesce_possible;
    assign do_push  = accept & ~coalesce_possible;
    assign do_pop   = in_flight & dcache2stb_ack;

    genvar gi;
    generate
        for (gi = 0; gi < BYTE_SEL_WIDTH; gi++) begin : g_lane
            assign merge_data[gi*8 +: 8]  = lsudbus2stb_sel_byte[gi] ? lsudbus2stb_wdata[gi*8 +: 8]
                                                                     : data_reg[youngest_ptr][gi*8 +: 8];
            assign ld_fwd_data[gi*8 +: 8] = ld_sel_byte[gi] ? fwd_data[gi*8 +: 8] : 8'h00;
        end
    endgenerate

    always_comb begin
        count_next = count_reg;
        if (do_push && !do_pop) begin
            count_next = count_reg + CNT_ONE;
        end else if (!do_push && do_pop) begin
            count_next = count_reg - CNT_ONE;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (!empty) state_next = REQ;
            REQ:  if (do_pop && (count_next == '0)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Push and pop never target the same slot, and a merge never hits the
    // in-flight head, so the three writes below are mutually disjoint.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg  <= '0;
            addr_reg   <= '0;
            data_reg   <= '0;
            sel_reg    <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            state_reg  <= IDLE;
            ack_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            ack_reg   <= accept;
            if (do_push) begin
                valid_reg[wr_ptr_reg] <= 1'b1;
                addr_reg[wr_ptr_reg]  <= store_word;
                data_reg[wr_ptr_reg]  <= lsudbus2stb_wdata;
                sel_reg[wr_ptr_reg]   <= lsudbus2stb_sel_byte;
                wr_ptr_reg            <= wr_ptr_reg + PTR_ONE;
            end
            if (do_merge) begin
                data_reg[youngest_ptr] <= merge_data;
                sel_reg[youngest_ptr]  <= sel_reg[youngest_ptr] | lsudbus2stb_sel_byte;
            end
            if (do_pop) begin
                valid_reg[rd_ptr_reg] <= 1'b0;
                rd_ptr_reg            <= rd_ptr_reg + PTR_ONE;
            end
        end
    end

    stb_fwd_lookup #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .DATA_WIDTH     (DATA_WIDTH),
        .BYTE_SEL_WIDTH (BYTE_SEL_WIDTH),
        .FIFO_DEPTH     (FIFO_DEPTH),
        .PTR_W          (PTR_W)
    ) u_lookup (
        .ld_word     (ld_word),
        .entry_valid (valid_reg),
        .entry_addr  (addr_reg),
        .entry_data  (data_reg),
        .entry_sel   (sel_reg),
        .head_ptr    (rd_ptr_reg),
        .covered     (covered),
        .data        (fwd_data)
    );

    assign req_covered = covered & ld_sel_byte;
    assign ld_fwd_hit  = ld_valid && (req_covered == ld_sel_byte) && (ld_sel_byte != '0);
    assign ld_conflict = ld_valid && !ld_fwd_hit && (req_covered != '0);

    assign stb2dbuslsu_ack     = ack_reg;
    assign stb2dcache_addr     = addr_reg[rd_ptr_reg];
    assign stb2dcache_wdata    = data_reg[rd_ptr_reg];
    assign stb2dcache_sel_byte = sel_reg[rd_ptr_reg];
    assign stb2dcache_req      = in_flight;
    assign stb2dcache_w_en     = in_flight;
    assign dmem_sel_o          = in_flight;
    assign stb2dcache_empty    = empty;

endmodule

// File: tb/tb_store_buffer_fwd.sv
// Directed bench for store_buffer_fwd: one coalescing and one non-coalescing
// instance share all stimulus; each task checks its scenario inline.
module tb_store_buffer_fwd;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] st_addr, st_wdata, ld_addr;
    logic [3:0]  st_sel, ld_sel;
    logic        st_w_en, st_req, dmem_sel_i, ld_valid, fence, dc_ack;

    logic        a_stall, a_ack, a_hit, a_conf, a_w_en, a_req, a_dsel, a_empty;
    logic [31:0] a_fdata, a_addr, a_wdata;
    logic [3:0]  a_sel;
    logic        b_stall, b_ack, b_hit, b_conf, b_w_en, b_req, b_dsel, b_empty;
    logic [31:0] b_fdata, b_addr, b_wdata;
    logic [3:0]  b_sel;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    store_buffer_fwd #(.FIFO_DEPTH(4), .COALESCE_EN(1'b1)) u_dut (
        .clk(clk), .rst(rst),
        .lsudbus2stb_addr(st_addr), .lsudbus2stb_wdata(st_wdata), .lsudbus2stb_sel_byte(st_sel),
        .lsudbus2stb_w_en(st_w_en), .lsudbus2stb_req(st_req), .dmem_sel_i(dmem_sel_i),
        .stb2dbuslsu_stall(a_stall), .stb2dbuslsu_ack(a_ack),
        .ld_addr(ld_addr), .ld_sel_byte(ld_sel), .ld_valid(ld_valid),
        .ld_fwd_hit(a_hit), .ld_fwd_data(a_fdata), .ld_conflict(a_conf),
        .fence_i(fence),
        .stb2dcache_addr(a_addr), .stb2dcache_wdata(a_wdata), .stb2dcache_sel_byte(a_sel),
        .stb2dcache_w_en(a_w_en), .stb2dcache_req(a_req), .dmem_sel_o(a_dsel),
        .dcache2stb_ack(dc_ack), .stb2dcache_empty(a_empty)
    );

    store_buffer_fwd #(.FIFO_DEPTH(4), .COALESCE_EN(1'b0)) u_dut_nc (
        .clk(clk), .rst(rst),
        .lsudbus2stb_addr(st_addr), .lsudbus2stb_wdata(st_wdata), .lsudbus2stb_sel_byte(st_sel),
        .lsudbus2stb_w_en(st_w_en), .lsudbus2stb_req(st_req), .dmem_sel_i(dmem_sel_i),
        .stb2dbuslsu_stall(b_stall), .stb2dbuslsu_ack(b_ack),
        .ld_addr(ld_addr), .ld_sel_byte(ld_sel), .ld_valid(ld_valid),
        .ld_fwd_hit(b_hit), .ld_fwd_data(b_fdata), .ld_conflict(b_conf),
        .fence_i(fence),
        .stb2dcache_addr(b_addr), .stb2dcache_wdata(b_wdata), .stb2dcache_sel_byte(b_sel),
        .stb2dcache_w_en(b_w_en), .stb2dcache_req(b_req), .dmem_sel_o(b_dsel),
        .dcache2stb_ack(dc_ack), .stb2dcache_empty(b_empty)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        st_addr = '0; st_wdata = '0; st_sel = '0; st_w_en = 1'b0; st_req = 1'b0;
        dmem_sel_i = 1'b0; ld_addr = '0; ld_sel = '0; ld_valid = 1'b0;
        fence = 1'b0; dc_ack = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] sel);
        st_addr = addr; st_wdata = data; st_sel = sel;
        st_w_en = 1'b1; st_req = 1'b1; dmem_sel_i = 1'b1;
        step();
        st_req = 1'b0; st_w_en = 1'b0;
    endtask

    task automatic wait_req_a(output bit seen);
        for (int k = 0; k < 20 && a_req !== 1'b1; k++) step();
        seen = (a_req === 1'b1);
    endtask

    task automatic test_reset();
        apply_reset();
        total++;
        if ({a_stall, a_ack, a_req, a_w_en, a_dsel, a_empty} !== 6'b000001) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 000001", {a_stall, a_ack, a_req, a_w_en, a_dsel, a_empty});
        end
        total++;
        if ({a_addr, a_wdata, a_sel} !== 68'h0) begin
            bad++;
            $display("FAIL reset_head: got %h %h %h want zeros", a_addr, a_wdata, a_sel);
        end
    endtask

    task automatic test_fill_drain();
        bit seen;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            store(32'(i * 4), 32'hA0A0_0000 | 32'(i), 4'hF);
            total++;
            if (a_ack !== 1'b1) begin
                bad++;
                $display("FAIL fill_ack%0d: got %b want 1", i, a_ack);
            end
        end
        st_addr = 32'h50;
        #1;
        total++;
        if (a_stall !== 1'b1) begin
            bad++;
            $display("FAIL fill_stall_full: got %b want 1", a_stall);
        end
        for (int i = 0; i < 4; i++) begin
            wait_req_a(seen);
            total++;
            if (!seen) begin
                bad++;
                $display("FAIL drain_req%0d: got 0 want 1", i);
            end
            step();
            step();
            total++;
            if ({a_addr, a_wdata, a_sel} !== {32'(i * 4), 32'hA0A0_0000 | 32'(i), 4'hF}) begin
                bad++;
                $display("FAIL drain_head%0d: got %h %h %h want %h %h f", i, a_addr, a_wdata, a_sel,
                         32'(i * 4), 32'hA0A0_0000 | 32'(i));
            end
            dc_ack = 1'b1;
            step();
            dc_ack = 1'b0;
        end
        total++;
        if ({a_empty, a_req} !== 2'b10) begin
            bad++;
            $display("FAIL drain_end: got empty/req %b want 10", {a_empty, a_req});
        end
    endtask

    task automatic test_coalesce();
        bit seen;
        apply_reset();
        store(32'h40, 32'h1234_5678, 4'hF);
        store(32'h10, 32'h0000_BBAA, 4'b0011);
        store(32'h10, 32'hDDCC_0000, 4'b1100);
        wait_req_a(seen);
        total++;
        if (!seen || a_addr !== 32'h40) begin
            bad++;
            $display("FAIL coal_first: got req %b addr %h want 1 00000040", a_req, a_addr);
        end
        dc_ack = 1'b1;
        step();
        dc_ack = 1'b0;
        total++;
        if ({a_req, a_addr, a_wdata, a_sel} !== {1'b1, 32'h10, 32'hDDCC_BBAA, 4'hF}) begin
            bad++;
            $display("FAIL coal_merged: got %b %h %h %h want 1 00000010 ddccbbaa f", a_req, a_addr, a_wdata, a_sel);
        end
        dc_ack = 1'b1;
        step();
        dc_ack = 1'b0;
        total++;
        if (a_empty !== 1'b1) begin
            bad++;
            $display("FAIL coal_single_entry: got empty %b want 1", a_empty);
        end
    endtask

    task automatic test_no_coalesce();
        apply_reset();
        store(32'h20, 32'h1111_1111, 4'hF);
        store(32'h20, 32'h0000_0022, 4'b0001);
        ld_addr = 32'h20; ld_sel = 4'hF; ld_valid = 1'b1;
        #1;
        total++;
        if ({b_hit, b_conf, b_fdata} !== {2'b10, 32'h1111_1122}) begin
            bad++;
            $display("FAIL nc_fwd: got %b %b %h want 1 0 11111122", b_hit, b_conf, b_fdata);
        end
        total++;
        if ({a_hit, a_fdata} !== {1'b1, 32'h1111_1122}) begin
            bad++;
            $display("FAIL coal_fwd: got %b %h want 1 11111122", a_hit, a_fdata);
        end
        ld_valid = 1'b0;
        total++;
        if ({b_req, b_addr, b_wdata, b_sel} !== {1'b1, 32'h20, 32'h1111_1111, 4'hF}) begin
            bad++;
            $display("FAIL nc_head0: got %b %h %h %h want 1 00000020 11111111 f", b_req, b_addr, b_wdata, b_sel);
        end
        dc_ack = 1'b1;
        step();
        dc_ack = 1'b0;
        total++;
        if ({b_req, b_wdata, b_sel} !== {1'b1, 32'h0000_0022, 4'b0001}) begin
            bad++;
            $display("FAIL nc_head1: got %b %h %h want 1 00000022 1", b_req, b_wdata, b_sel);
        end
        dc_ack = 1'b1;
        step();
        dc_ack = 1'b0;
        total++;
        if ({b_empty, a_empty, a_req} !== 3'b110) begin
            bad++;
            $display("FAIL nc_end_idle_ack: got %b want 110", {b_empty, a_empty, a_req});
        end
    endtask

    task automatic test_forward();
        apply_reset();
        store(32'h30, 32'h0000_BEEF, 4'b0011);
        ld_valid = 1'b1; ld_addr = 32'h30; ld_sel = 4'hF;
        #1;
        total++;
        if ({a_hit, a_conf} !== 2'b01) begin
            bad++;
            $display("FAIL fwd_conflict: got hit/conf %b want 01", {a_hit, a_conf});
        end
        ld_sel = 4'b0011;
        #1;
        total++;
        if ({a_hit, a_conf, a_fdata} !== {2'b10, 32'h0000_BEEF}) begin
            bad++;
            $display("FAIL fwd_hit: got %b %h want 10 0000beef", {a_hit, a_conf}, a_fdata);
        end
        ld_addr = 32'h32; ld_sel = 4'b0001;
        #1;
        total++;
        if ({a_hit, a_fdata} !== {1'b1, 32'h0000_00EF}) begin
            bad++;
            $display("FAIL fwd_byte: got %b %h want 1 000000ef", a_hit, a_fdata);
        end
        ld_addr = 32'h34; ld_sel = 4'hF;
        #1;
        total++;
        if ({a_hit, a_conf} !== 2'b00) begin
            bad++;
            $display("FAIL fwd_miss: got hit/conf %b want 00", {a_hit, a_conf});
        end
        step();
        ld_addr = 32'h38;
        st_addr = 32'h38; st_wdata = 32'h5555_5555; st_sel = 4'hF;
        st_w_en = 1'b1; st_req = 1'b1; dmem_sel_i = 1'b1;
        #1;
        total++;
        if ({a_hit, a_conf} !== 2'b00) begin
            bad++;
            $display("FAIL fwd_same_cycle: got hit/conf %b want 00", {a_hit, a_conf});
        end
        step();
        st_req = 1'b0; st_w_en = 1'b0;
        ld_valid = 1'b0; ld_addr = 32'h30; ld_sel = 4'b0011;
        #1;
        total++;
        if ({a_hit, a_conf} !== 2'b00) begin
            bad++;
            $display("FAIL fwd_not_valid: got hit/conf %b want 00", {a_hit, a_conf});
        end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] exp_addr [4];
        logic [31:0] exp_data [4];
        exp_addr = '{32'h104, 32'h108, 32'h10C, 32'h200};
        exp_data = '{32'hC1, 32'hC2, 32'hC3, 32'hC4};
        apply_reset();
        for (int i = 0; i < 4; i++) store(32'h100 + 32'(4 * i), 32'hC0 + 32'(i), 4'hF);
        st_addr = 32'h200; st_wdata = 32'hC4; st_sel = 4'hF;
        st_w_en = 1'b1; st_req = 1'b1; dmem_sel_i = 1'b1; dc_ack = 1'b1;
        #1;
        total++;
        if (a_stall !== 1'b1) begin
            bad++;
            $display("FAIL full_pop_stall: got %b want 1", a_stall);
        end
        step();
        dc_ack = 1'b0;
        total++;
        if ({a_ack, a_stall} !== 2'b00) begin
            bad++;
            $display("FAIL full_pop_next: got ack/stall %b want 00", {a_ack, a_stall});
        end
        step();
        st_req = 1'b0; st_w_en = 1'b0;
        total++;
        if (a_ack !== 1'b1) begin
            bad++;
            $display("FAIL full_push_retry: got ack %b want 1", a_ack);
        end
        dc_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({a_req, a_addr, a_wdata} !== {1'b1, exp_addr[i], exp_data[i]}) begin
                bad++;
                $display("FAIL wrap_drain%0d: got %b %h %h want 1 %h %h", i, a_req, a_addr, a_wdata,
                         exp_addr[i], exp_data[i]);
            end
            step();
        end
        dc_ack = 1'b0;
        total++;
        if ({a_empty, a_req} !== 2'b10) begin
            bad++;
            $display("FAIL wrap_end: got empty/req %b want 10", {a_empty, a_req});
        end
    endtask

    task automatic test_fence_reset();
        apply_reset();
        for (int i = 0; i < 3; i++) store(32'h400 + 32'(4 * i), 32'hF0 + 32'(i), 4'hF);
        fence = 1'b1;
        st_addr = 32'h500; st_wdata = 32'h1; st_sel = 4'hF;
        st_w_en = 1'b1; st_req = 1'b1; dmem_sel_i = 1'b1;
        #1;
        total++;
        if (a_stall !== 1'b1) begin
            bad++;
            $display("FAIL fence_stall: got %b want 1", a_stall);
        end
        step();
        st_req = 1'b0; st_w_en = 1'b0;
        total++;
        if (a_ack !== 1'b0) begin
            bad++;
            $display("FAIL fence_reject: got ack %b want 0", a_ack);
        end
        dc_ack = 1'b1;
        step();
        step();
        total++;
        if (a_empty !== 1'b0) begin
            bad++;
            $display("FAIL fence_two_acks: got empty %b want 0", a_empty);
        end
        step();
        dc_ack = 1'b0;
        total++;
        if ({a_empty, a_stall} !== 2'b11) begin
            bad++;
            $display("FAIL fence_done: got empty/stall %b want 11", {a_empty, a_stall});
        end
        fence = 1'b0;
        store(32'h600, 32'h66, 4'hF);
        store(32'h604, 32'h67, 4'hF);
        total++;
        if (a_req !== 1'b1) begin
            bad++;
            $display("FAIL rst_pre_req: got %b want 1", a_req);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({a_empty, a_req, a_dsel} !== 3'b100) begin
            bad++;
            $display("FAIL rst_mid_req: got empty/req/dsel %b want 100", {a_empty, a_req, a_dsel});
        end
        step();
        rst = 1'b0;
        step();
        total++;
        if ({a_empty, a_req} !== 2'b10) begin
            bad++;
            $display("FAIL rst_after: got empty/req %b want 10", {a_empty, a_req});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill_drain();
        test_coalesce();
        test_no_coalesce();
        test_forward();
        test_full_push_pop();
        test_fence_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
